// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// irq_controller: rising-edge interrupt latch with fixed-priority req/ack to CPU
// Revision 1.0
// ============================================================================
module irq_controller #(
  parameter int                   NUM_IRQ    = 8,
  parameter int                   ID_W       = 3,
  parameter logic [NUM_IRQ-1:0]   MASK_RESET = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_in,
  input  logic               clr_we,
  input  logic [NUM_IRQ-1:0] clr_in,
  input  logic               irq_ack,
  output logic               cpu_irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] mask_out,
  output logic [NUM_IRQ-1:0] pending_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               cpu_irq_q, cpu_irq_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] prev_q, prev_d;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clear;
  logic [NUM_IRQ-1:0] req;
  logic [ID_W-1:0]    winner;
  logic               ack_clear;

  always_comb begin
    rise      = irq_in & ~prev_q;
    ack_clear = (state_q == S_REQ) && irq_ack;
    clear     = (clr_we ? clr_in : '0)
              | (ack_clear ? (NUM_IRQ'(1) << irq_id_q) : '0);
    req       = pending_q & ~mask_q;

    // Scan downward so the lowest set index is the last one written.
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) winner = ID_W'(i);
    end

    prev_d    = irq_in;
    pending_d = (pending_q & ~clear) | rise;
    mask_d    = mask_we ? mask_in : mask_q;
    state_d   = state_q;
    cpu_irq_d = cpu_irq_q;
    irq_id_d  = irq_id_q;

    case (state_q)
      S_IDLE: begin
        if (req != '0) begin
          irq_id_d  = winner;
          cpu_irq_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (irq_ack) begin
          cpu_irq_d = 1'b0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        cpu_irq_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        cpu_irq_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // Sampling irq_in at reset suppresses events from lines already high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cpu_irq_q <= 1'b0;
      irq_id_q  <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RESET;
      prev_q    <= irq_in;
    end else begin
      state_q   <= state_d;
      cpu_irq_q <= cpu_irq_d;
      irq_id_q  <= irq_id_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      prev_q    <= prev_d;
    end
  end

  assign cpu_irq     = cpu_irq_q;
  assign irq_id      = irq_id_q;
  assign mask_out    = mask_q;
  assign pending_out = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// tb_irq_controller: directed scenarios plus randomized traffic vs a reference model
// Revision 1.0
// ============================================================================
module tb_irq_controller;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] irq_in = '0;
  logic         mask_we = 1'b0;
  logic [N-1:0] mask_in = '0;
  logic         clr_we = 1'b0;
  logic [N-1:0] clr_in = '0;
  logic         irq_ack = 1'b0;
  logic         cpu_irq;
  logic [2:0]   irq_id;
  logic [N-1:0] mask_out;
  logic [N-1:0] pending_out;

  irq_controller #(.NUM_IRQ(N), .ID_W(3), .MASK_RESET(8'h00)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in),
    .mask_we(mask_we), .mask_in(mask_in),
    .clr_we(clr_we), .clr_in(clr_in),
    .irq_ack(irq_ack), .cpu_irq(cpu_irq), .irq_id(irq_id),
    .mask_out(mask_out), .pending_out(pending_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = waiting, 1 = presenting, 2 = forced low cycle.
  bit [N-1:0] m_pend, m_mask, m_prev;
  int         m_phase;
  bit         m_cpu;
  int         m_id;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input bit [N-1:0] irq, input bit mwe, input bit [N-1:0] min,
                            input bit cwe, input bit [N-1:0] cin, input bit ack, input bit rst);
    bit [N-1:0] rises, clrs, cand;
    if (rst) begin
      m_pend = '0; m_mask = '0; m_prev = irq; m_phase = 0; m_cpu = 0; m_id = 0;
      return;
    end
    rises = irq & ~m_prev;
    clrs  = cwe ? cin : '0;
    if (m_phase == 1 && ack) clrs[m_id] = 1'b1;
    cand  = m_pend & ~m_mask;
    if (m_phase == 0) begin
      if (lowest(cand) >= 0) begin
        m_id = lowest(cand); m_cpu = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (ack) begin m_cpu = 0; m_phase = 2; end
    end else begin
      m_phase = 0;
    end
    m_pend = (m_pend & ~clrs) | rises;
    m_prev = irq;
    if (mwe) m_mask = min;
  endtask

  task automatic cyc(input logic [N-1:0] irq, input logic mwe, input logic [N-1:0] min,
                     input logic cwe, input logic [N-1:0] cin, input logic ack, input logic rst);
    irq_in = irq; mask_we = mwe; mask_in = min; clr_we = cwe; clr_in = cin;
    irq_ack = ack; reset = rst;
    @(posedge clk);
    model_step(irq, mwe, min, cwe, cin, ack, rst);
    #1;
    check("cpu_irq", 32'(cpu_irq), 32'(m_cpu));
    check("irq_id", 32'(irq_id), 32'(m_id));
    check("mask_out", 32'(mask_out), 32'(m_mask));
    check("pending_out", 32'(pending_out), 32'(m_pend));
  endtask

  task automatic idle(input logic [N-1:0] irq);
    cyc(irq, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic ackc(input logic [N-1:0] irq);
    cyc(irq, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic wmask(input logic [N-1:0] irq, input logic [N-1:0] m);
    cyc(irq, 1'b1, m, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [N-1:0] r_irq;

    // Reset state
    cyc('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    cyc('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    check("rst_cpu", 32'(cpu_irq), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    check("rst_pend", 32'(pending_out), 32'h00);
    check("rst_mask", 32'(mask_out), 32'h00);

    // Single event held for 16 cycles
    idle(8'h08);
    check("single_pend", 32'(pending_out), 32'h08);
    check("single_cpu_early", 32'(cpu_irq), 32'd0);
    idle(8'h08);
    check("single_cpu", 32'(cpu_irq), 32'd1);
    check("single_id", 32'(irq_id), 32'd3);
    repeat (3) idle(8'h08);
    ackc(8'h08);
    check("single_ack_pend", 32'(pending_out), 32'h00);
    check("single_ack_cpu", 32'(cpu_irq), 32'd0);
    repeat (10) idle(8'h08);
    check("single_no_repeat", 32'(cpu_irq), 32'd0);
    idle('0);

    // Priority between simultaneous edges
    idle(8'h22);
    idle(8'h22);
    check("prio_first", 32'(irq_id), 32'd1);
    ackc(8'h22);
    check("prio_drop", 32'(cpu_irq), 32'd0);
    idle(8'h22);
    check("prio_gap", 32'(cpu_irq), 32'd0);
    idle(8'h22);
    check("prio_second_cpu", 32'(cpu_irq), 32'd1);
    check("prio_second_id", 32'(irq_id), 32'd5);
    ackc(8'h22);
    check("prio_done", 32'(pending_out), 32'h00);
    idle('0);

    // Masking gates arbitration but not latching
    wmask('0, 8'h04);
    idle(8'h04);
    check("mask_pend", 32'(pending_out), 32'h04);
    idle(8'h04);
    idle(8'h04);
    check("mask_blocked", 32'(cpu_irq), 32'd0);
    wmask(8'h04, 8'h00);
    idle(8'h04);
    check("unmask_cpu", 32'(cpu_irq), 32'd1);
    check("unmask_id", 32'(irq_id), 32'd2);
    ackc('0);
    idle('0);

    // Edge coinciding with the ack of the same line
    idle(8'h10);
    idle(8'h10);
    check("coll_id", 32'(irq_id), 32'd4);
    idle('0);
    ackc(8'h10);
    check("coll_pend", 32'(pending_out), 32'h10);
    idle(8'h10);
    check("coll_gap", 32'(cpu_irq), 32'd0);
    idle(8'h10);
    check("coll_re_cpu", 32'(cpu_irq), 32'd1);
    check("coll_re_id", 32'(irq_id), 32'd4);
    ackc(8'h10);
    check("coll_done", 32'(pending_out), 32'h00);
    idle('0);

    // Software clear and stray ack
    wmask('0, 8'h40);
    idle(8'h40);
    check("swclr_set", 32'(pending_out), 32'h40);
    cyc(8'h40, 1'b0, '0, 1'b1, 8'h40, 1'b0, 1'b0);
    check("swclr_pend", 32'(pending_out), 32'h00);
    ackc(8'h40);
    check("stray_cpu", 32'(cpu_irq), 32'd0);
    check("stray_pend", 32'(pending_out), 32'h00);
    check("stray_mask", 32'(mask_out), 32'h40);
    wmask('0, 8'h00);

    // Reset in the middle of a handshake
    idle(8'h01);
    idle(8'h01);
    check("midrst_pre", 32'(cpu_irq), 32'd1);
    cyc(8'h01, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    check("midrst_cpu", 32'(cpu_irq), 32'd0);
    check("midrst_pend", 32'(pending_out), 32'h00);
    check("midrst_mask", 32'(mask_out), 32'h00);
    repeat (5) idle(8'h01);
    check("midrst_quiet", 32'(cpu_irq), 32'd0);
    idle('0);

    // Randomized traffic
    r_irq = '0;
    for (int k = 0; k < 3000; k++) begin
      r_irq = r_irq ^ N'($urandom & $urandom & $urandom);
      cyc(r_irq,
          ($urandom_range(15) == 0), N'($urandom & $urandom),
          ($urandom_range(15) == 0), N'($urandom),
          ($urandom_range(2) == 0),
          ($urandom_range(199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
